// File: rtl/decode_execute_reg.sv
// decode_execute_reg: decode-to-execute pipeline register with load-use hazard
// detection, execute back-pressure hold, flush kill and a saturating stall counter.
module decode_execute_reg #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [IDX_W-1:0]  id_r2_idx,
    input  logic [IDX_W-1:0]  id_r3_idx,
    input  logic              id_use_r2,
    input  logic              id_use_r3,
    input  logic [DATA_W-1:0] id_r2_val,
    input  logic [DATA_W-1:0] id_r3_val,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [IDX_W-1:0]  id_dest,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [IDX_W-1:0]  ex_r2_idx,
    output logic [IDX_W-1:0]  ex_r3_idx,
    output logic [IDX_W-1:0]  ex_dest,
    output logic [DATA_W-1:0] ex_r2_val,
    output logic [DATA_W-1:0] ex_r3_val,
    output logic [DATA_W-1:0] ex_imm,
    output logic [3:0]        ex_alu_op,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);
    logic hit_r2, hit_r3, lu;

    assign hit_r2 = id_use_r2 && (id_r2_idx == ex_dest);
    assign hit_r3 = id_use_r3 && (id_r3_idx == ex_dest);
    assign lu     = ex_valid && ex_mem_read && ex_reg_write && id_valid && (hit_r2 || hit_r3);
    // ex_busy is not honoured while reset is asserted
    assign stall  = rst_n && !flush && (ex_busy || lu);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (flush || (!ex_busy && lu)) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (!ex_busy) begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
            ex_mem_write <= id_valid && id_mem_write;
        end
    end

    // data fields are don't-care on flush, so they simply hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_r2_idx <= '0;
            ex_r3_idx <= '0;
            ex_dest   <= '0;
            ex_r2_val <= '0;
            ex_r3_val <= '0;
            ex_imm    <= '0;
            ex_alu_op <= '0;
        end else if (!flush && !ex_busy && !lu) begin
            ex_r2_idx <= id_r2_idx;
            ex_r3_idx <= id_r3_idx;
            ex_dest   <= id_dest;
            ex_r2_val <= id_r2_val;
            ex_r3_val <= id_r3_val;
            ex_imm    <= id_imm;
            ex_alu_op <= id_alu_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_decode_execute_reg.sv
// tb_decode_execute_reg: directed table, corner sequences and randomized run
// against a rule-level model of the decode/execute register.
module tb_decode_execute_reg;
    localparam int CMAX = 15;

    typedef struct {
        logic v, u2, u3, rw, mr, mw, fl, bz;
        logic [3:0] r2i, r3i, d, op;
        logic [31:0] r2v, r3v, imm;
    } in_t;

    typedef struct {
        in_t i;
        logic xs, xv, xrw, xmr, xmw;
        logic [3:0] xd;
        logic [31:0] xr2;
        logic [3:0] xc;
        bit cd;
    } row_t;

    typedef struct {
        logic v, rw, mr, mw;
        bit known;
        logic [3:0] d, r2i, r3i, op;
        logic [31:0] r2v, r3v, imm;
        int cnt;
    } st_t;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_r2, id_use_r3, id_reg_write, id_mem_read, id_mem_write, flush, ex_busy;
    logic [3:0] id_r2_idx, id_r3_idx, id_dest, id_alu_op;
    logic [31:0] id_r2_val, id_r3_val, id_imm;
    logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, stall;
    logic [3:0] ex_r2_idx, ex_r3_idx, ex_dest, ex_alu_op;
    logic [31:0] ex_r2_val, ex_r3_val, ex_imm;
    logic [3:0] stall_count;

    int n_vec = 0;
    int n_err = 0;
    row_t tbl[$];
    st_t st;

    always #5 clk = ~clk;

    decode_execute_reg #(.DATA_W(32), .IDX_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_r2_idx(id_r2_idx), .id_r3_idx(id_r3_idx),
        .id_use_r2(id_use_r2), .id_use_r3(id_use_r3),
        .id_r2_val(id_r2_val), .id_r3_val(id_r3_val), .id_imm(id_imm),
        .id_dest(id_dest), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush), .ex_busy(ex_busy),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_r2_idx(ex_r2_idx), .ex_r3_idx(ex_r3_idx),
        .ex_dest(ex_dest), .ex_r2_val(ex_r2_val), .ex_r3_val(ex_r3_val), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .stall(stall), .stall_count(stall_count)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input in_t i);
        id_valid = i.v; id_use_r2 = i.u2; id_use_r3 = i.u3;
        id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw;
        flush = i.fl; ex_busy = i.bz;
        id_r2_idx = i.r2i; id_r3_idx = i.r3i; id_dest = i.d; id_alu_op = i.op;
        id_r2_val = i.r2v; id_r3_val = i.r3v; id_imm = i.imm;
    endtask

    function automatic in_t mkin(logic v, logic u2, logic [3:0] r2i, logic [3:0] d, logic [31:0] r2v,
                                 logic rw, logic mr, logic mw, logic fl, logic bz);
        in_t i;
        i.v = v; i.u2 = u2; i.u3 = 1'b0; i.rw = rw; i.mr = mr; i.mw = mw; i.fl = fl; i.bz = bz;
        i.r2i = r2i; i.r3i = 4'd0; i.d = d; i.op = d;
        i.r2v = r2v; i.r3v = r2v ^ 32'hA5A5_A5A5; i.imm = r2v + 32'd1;
        return i;
    endfunction

    function automatic void add(in_t i, logic xs, logic xv, logic xrw, logic xmr, logic xmw,
                                logic [3:0] xd, logic [31:0] xr2, logic [3:0] xc, bit cd);
        row_t r;
        r.i = i; r.xs = xs; r.xv = xv; r.xrw = xrw; r.xmr = xmr; r.xmw = xmw;
        r.xd = xd; r.xr2 = xr2; r.xc = xc; r.cd = cd;
        tbl.push_back(r);
    endfunction

    function automatic bit m_lu(st_t s, in_t i);
        return s.v && s.mr && s.rw && i.v && ((i.u2 && i.r2i == s.d) || (i.u3 && i.r3i == s.d));
    endfunction

    function automatic bit m_stall(st_t s, in_t i);
        return !i.fl && (i.bz || m_lu(s, i));
    endfunction

    function automatic st_t m_next(st_t s, in_t i);
        st_t n = s;
        if (m_stall(s, i)) n.cnt = (s.cnt + 1 > CMAX) ? CMAX : s.cnt + 1;
        if (i.fl) begin
            n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0; n.known = 0;
        end else if (i.bz) begin
        end else if (m_lu(s, i)) begin
            n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
        end else begin
            n.v = i.v; n.rw = i.v & i.rw; n.mr = i.v & i.mr; n.mw = i.v & i.mw; n.known = 1;
            n.d = i.d; n.r2i = i.r2i; n.r3i = i.r3i; n.op = i.op;
            n.r2v = i.r2v; n.r3v = i.r3v; n.imm = i.imm;
        end
        return n;
    endfunction

    task automatic check_model(input string tag);
        cmp({tag, " ex_valid"}, 32'(ex_valid), 32'(st.v));
        cmp({tag, " ex_reg_write"}, 32'(ex_reg_write), 32'(st.rw));
        cmp({tag, " ex_mem_read"}, 32'(ex_mem_read), 32'(st.mr));
        cmp({tag, " ex_mem_write"}, 32'(ex_mem_write), 32'(st.mw));
        cmp({tag, " stall_count"}, 32'(stall_count), 32'(st.cnt));
        if (st.known) begin
            cmp({tag, " ex_dest"}, 32'(ex_dest), 32'(st.d));
            cmp({tag, " ex_r2_idx"}, 32'(ex_r2_idx), 32'(st.r2i));
            cmp({tag, " ex_r3_idx"}, 32'(ex_r3_idx), 32'(st.r3i));
            cmp({tag, " ex_alu_op"}, 32'(ex_alu_op), 32'(st.op));
            cmp({tag, " ex_r2_val"}, ex_r2_val, st.r2v);
            cmp({tag, " ex_r3_val"}, ex_r3_val, st.r3v);
            cmp({tag, " ex_imm"}, ex_imm, st.imm);
        end
    endtask

    initial begin
        in_t ri;
        rst_n = 1'b0;
        drive(mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        cmp("reset ex_valid", 32'(ex_valid), 0);
        cmp("reset stall_count", 32'(stall_count), 0);
        cmp("reset ex_r2_val", ex_r2_val, 0);
        cmp("reset stall", 32'(stall), 0);
        tick(); tick();
        rst_n = 1'b1;

        // inputs: v u2 r2i dest r2v rw mr mw fl bz | stall valid rw mr mw dest r2v cnt chk_data
        add(mkin(1, 0, 0, 3, 32'h5, 1, 0, 0, 0, 0), 0, 1, 1, 0, 0, 3, 32'h5, 0, 1);
        add(mkin(1, 0, 0, 5, 32'h7, 1, 0, 0, 0, 0), 0, 1, 1, 0, 0, 5, 32'h7, 0, 1);
        add(mkin(1, 0, 0, 4, 32'h9, 1, 1, 0, 0, 0), 0, 1, 1, 1, 0, 4, 32'h9, 0, 1);
        add(mkin(1, 1, 4, 6, 32'h11, 1, 0, 0, 0, 0), 1, 0, 0, 0, 0, 4, 32'h9, 1, 1);
        add(mkin(1, 1, 4, 6, 32'h11, 1, 0, 0, 0, 0), 0, 1, 1, 0, 0, 6, 32'h11, 1, 1);
        add(mkin(1, 0, 0, 4, 32'h22, 1, 1, 0, 0, 0), 0, 1, 1, 1, 0, 4, 32'h22, 1, 1);
        add(mkin(1, 1, 12, 7, 32'h33, 1, 0, 0, 0, 0), 0, 1, 1, 0, 0, 7, 32'h33, 1, 1);
        add(mkin(1, 0, 0, 4, 32'h44, 1, 1, 0, 0, 0), 0, 1, 1, 1, 0, 4, 32'h44, 1, 1);
        add(mkin(1, 0, 0, 9, 32'h55, 1, 0, 1, 0, 1), 1, 1, 1, 1, 0, 4, 32'h44, 2, 1);
        add(mkin(1, 0, 0, 9, 32'h55, 1, 0, 1, 0, 1), 1, 1, 1, 1, 0, 4, 32'h44, 3, 1);
        add(mkin(1, 0, 0, 9, 32'h55, 1, 0, 1, 0, 1), 1, 1, 1, 1, 0, 4, 32'h44, 4, 1);
        add(mkin(1, 1, 4, 6, 32'h66, 1, 0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 32'h0, 4, 0);
        add(mkin(1, 0, 0, 2, 32'h77, 0, 0, 1, 0, 0), 0, 1, 0, 0, 1, 2, 32'h77, 4, 1);
        add(mkin(0, 0, 0, 8, 32'h88, 1, 1, 1, 0, 0), 0, 0, 0, 0, 0, 8, 32'h88, 4, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            string t;
            t = $sformatf("row%0d", k);
            drive(tbl[k].i);
            #1;
            cmp({t, " stall"}, 32'(stall), 32'(tbl[k].xs));
            tick();
            cmp({t, " ex_valid"}, 32'(ex_valid), 32'(tbl[k].xv));
            cmp({t, " ex_reg_write"}, 32'(ex_reg_write), 32'(tbl[k].xrw));
            cmp({t, " ex_mem_read"}, 32'(ex_mem_read), 32'(tbl[k].xmr));
            cmp({t, " ex_mem_write"}, 32'(ex_mem_write), 32'(tbl[k].xmw));
            cmp({t, " stall_count"}, 32'(stall_count), 32'(tbl[k].xc));
            if (tbl[k].cd) begin
                cmp({t, " ex_dest"}, 32'(ex_dest), 32'(tbl[k].xd));
                cmp({t, " ex_r2_val"}, ex_r2_val, tbl[k].xr2);
                cmp({t, " ex_imm"}, ex_imm, tbl[k].xr2 + 32'd1);
            end
        end

        // asynchronous reset mid-stream with a live instruction and count 7
        drive(mkin(1, 0, 0, 1, 32'hAB, 1, 0, 0, 0, 0));
        tick();
        drive(mkin(1, 0, 0, 9, 32'hCD, 1, 0, 0, 0, 1));
        repeat (3) tick();
        cmp("pre-reset stall_count", 32'(stall_count), 7);
        cmp("pre-reset ex_valid", 32'(ex_valid), 1);
        cmp("pre-reset ex_r2_val", ex_r2_val, 32'hAB);
        ex_busy = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        cmp("async reset ex_valid", 32'(ex_valid), 0);
        cmp("async reset ex_reg_write", 32'(ex_reg_write), 0);
        cmp("async reset ex_dest", 32'(ex_dest), 0);
        cmp("async reset ex_r2_val", ex_r2_val, 0);
        cmp("async reset stall_count", 32'(stall_count), 0);
        cmp("async reset stall", 32'(stall), 0);
        tick();
        rst_n = 1'b1;
        drive(mkin(1, 0, 0, 5, 32'hEE, 1, 1, 0, 0, 0));
        tick();
        cmp("post-reset load ex_valid", 32'(ex_valid), 1);
        cmp("post-reset load ex_dest", 32'(ex_dest), 5);
        cmp("post-reset load ex_r2_val", ex_r2_val, 32'hEE);

        // stall counter saturation
        ex_busy = 1'b1;
        repeat (14) tick();
        cmp("count at 14", 32'(stall_count), 14);
        tick();
        cmp("count saturates", 32'(stall_count), CMAX);
        repeat (3) tick();
        cmp("count holds at max", 32'(stall_count), CMAX);
        ex_busy = 1'b0;
        id_valid = 1'b0;
        #1;
        cmp("no stall after busy", 32'(stall), 0);

        // randomized run against the model, with periodic resets
        for (int n = 0; n < 400; n++) begin
            if (n % 64 == 0) begin
                ex_busy = 1'b0;
                flush = 1'b0;
                rst_n = 1'b0;
                #1;
                st = '{default: 0};
                st.known = 1;
                check_model("rand reset");
                tick();
                rst_n = 1'b1;
            end
            ri.v = ($urandom_range(0, 4) != 0);
            ri.u2 = $urandom_range(0, 1); ri.u3 = $urandom_range(0, 1);
            ri.rw = ($urandom_range(0, 3) != 0); ri.mr = ($urandom_range(0, 2) == 0);
            ri.mw = $urandom_range(0, 1);
            ri.fl = ($urandom_range(0, 9) == 0); ri.bz = ($urandom_range(0, 4) == 0);
            ri.r2i = 4'($urandom_range(0, 3)); ri.r3i = 4'($urandom_range(0, 3));
            ri.d = 4'($urandom_range(0, 3)); ri.op = 4'($urandom);
            ri.r2v = $urandom; ri.r3v = $urandom; ri.imm = $urandom;
            drive(ri);
            #1;
            cmp("rand stall", 32'(stall), 32'(m_stall(st, ri)));
            tick();
            st = m_next(st, ri);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/decode_execute_reg.md
DECODE_EXECUTE_REG -- requirements
Module: decode_execute_reg

Interface
REQ-001 Parameter DATA_W, default 32, operand/immediate width.
REQ-002 Parameter IDX_W, default 4, register-index width.
REQ-003 Parameter CNT_W, default 16, stall-counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 id_valid  input  1  decode slot holds a real instruction.
REQ-007 id_r2_idx, id_r3_idx  input  IDX_W each  source register indices.
REQ-008 id_use_r2, id_use_r3  input  1 each  instruction actually reads that source.
REQ-009 id_r2_val, id_r3_val  input  DATA_W each  register-file read data.
REQ-010 id_imm  input  DATA_W  decoded immediate.
REQ-011 id_dest  input  IDX_W  destination index.
REQ-012 id_alu_op  input  4  ALU operation code.
REQ-013 id_reg_write, id_mem_read, id_mem_write  input  1 each  control bits.
REQ-014 flush  input  1  branch/exception redirect; kill decode slot.
REQ-015 ex_busy  input  1  execute stage cannot accept a new instruction this cycle.
REQ-016 ex_valid, ex_reg_write, ex_mem_read, ex_mem_write  output  1 each  registered control.
REQ-017 ex_r2_idx, ex_r3_idx, ex_dest  output  IDX_W each  registered indices (consumed by the forwarding stage).
REQ-018 ex_r2_val, ex_r3_val, ex_imm  output  DATA_W each  registered data.
REQ-019 ex_alu_op  output  4  registered ALU op.
REQ-020 stall  output  1  combinational; freeze fetch and decode stages.
REQ-021 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-022 Load-use hazard lu = ex_valid & ex_mem_read & ex_reg_write & id_valid & ((id_use_r2 & id_r2_idx==ex_dest) | (id_use_r3 & id_r3_idx==ex_dest)); full-width equality compare, never bitwise AND.
REQ-023 stall = ~flush & (ex_busy | lu).
REQ-024 Per-edge priority, highest first: flush, ex_busy, lu, normal load.
REQ-025 flush: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write <= 0; data/index fields don't-care; ex_busy and lu ignored.
REQ-026 ex_busy (no flush): every output register holds its current value.
REQ-027 lu (no flush, no busy): bubble inserted -- four control bits <= 0, other fields unchanged; decode slot retained by stall.
REQ-028 Normal: all ex_* <= corresponding id_*; ex_valid <= id_valid; control bits gated by id_valid (0 when id_valid=0).
REQ-029 Latency: one cycle from decode inputs to ex_* outputs when not stalled.
REQ-030 Load-use stall lasts exactly one cycle: the bubble clears ex_mem_read, deasserting lu.
REQ-031 stall_count increments by 1 on each edge where stall=1; holds at 2^CNT_W-1 (no wrap).
REQ-032 Bubble/flush never asserts ex_mem_write or ex_reg_write.

Reset
REQ-033 rst_n=0 immediately (asynchronously) clears all ex_* outputs and stall_count to 0.
REQ-034 stall is 0 during reset, since ex_valid=0 and ex_busy is not sampled.
REQ-035 Reset deassertion mid-operation: first edge after rst_n=1 performs a normal load.

Verification
REQ-036 Back-to-back ALU ops: id_r2_val=0x0000_0005, id_dest=3 -> next cycle ex_r2_val=5, ex_dest=3, ex_valid=1, stall=0 throughout.
REQ-037 Load r4 then id_use_r2=1, id_r2_idx=4 -> stall=1 one cycle, ex_valid=0 bubble, next cycle consumer loads, stall_count=1.
REQ-038 Load r4 then consumer uses r12 (0b1100, shares bit 2 with 4) -> no stall, stall_count stays 0.
REQ-039 ex_busy=1 for 3 cycles with new decode data -> ex_* unchanged, stall=1, stall_count +3.
REQ-040 flush and ex_busy both 1 while load-use present -> ex_valid=0 next edge, stall=0.
REQ-041 rst_n pulsed low mid-stream with ex_valid=1, stall_count=7 -> all outputs 0 before next clk edge.
